cnn_layer_scheduler: RTL and testbench

//  Sequences the convolution and pooling datapath of cnn_accelerator for one feature-map pass.
//  - Walks every KERNEL_SIZE x KERNEL_SIZE convolution window, then every pooling window.
//  - Issues one window coordinate per handshake and reports completion on done.
//  - Sits between top-level en/done control and the MAC array / pool unit.

---
 rtl/cnn_layer_scheduler_pkg.sv | 18 +
 rtl/cnn_layer_scheduler_if.sv | 25 ++
 rtl/cnn_layer_scheduler_win_counter.sv | 37 +++
 rtl/cnn_layer_scheduler.sv | 105 ++++++++++
 tb/tb_cnn_layer_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_scheduler_pkg.sv
// Shared constants and types for the CNN layer scheduler: feature-map geometry,
// derived output sizes and the scheduler state encoding.
package cnn_layer_scheduler_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int IFMAP_SIZE      = 8;
    localparam int KERNEL_SIZE     = 3;
    localparam int POOL_SIZE       = 2;
    localparam int POOL_STRIDE     = 2;
    localparam int CONV_OFMAP_SIZE = IFMAP_SIZE - KERNEL_SIZE + 1;
    localparam int POOL_OFMAP_SIZE = (CONV_OFMAP_SIZE - POOL_SIZE) / POOL_STRIDE + 1;
    localparam int CW              = $clog2(IFMAP_SIZE);

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_DRAIN, S_POOL, S_DONE} sched_state_t;

endpackage

// File: rtl/cnn_layer_scheduler_if.sv
// Window-issue channels between the scheduler and the MAC array / pool unit.
interface cnn_layer_scheduler_if;
    import cnn_layer_scheduler_pkg::*;

    logic   conv_valid;
    logic   conv_ready;
    coord_t conv_row;
    coord_t conv_col;
    logic   dp_idle;
    logic   pool_valid;
    logic   pool_ready;
    coord_t pool_row;
    coord_t pool_col;

    modport master (
        output conv_valid, conv_row, conv_col, pool_valid, pool_row, pool_col,
        input  conv_ready, pool_ready, dp_idle
    );

    modport slave (
        input  conv_valid, conv_row, conv_col, pool_valid, pool_row, pool_col,
        output conv_ready, pool_ready, dp_idle
    );

endinterface

// File: rtl/cnn_layer_scheduler_win_counter.sv
// Row-major 2D window counter over a LIMIT x LIMIT grid; wraps to (0,0) after
// stepping from the last index.
module cnn_win_counter
    import cnn_layer_scheduler_pkg::*;
#(
    parameter int LIMIT = CONV_OFMAP_SIZE
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   step,
    output coord_t row,
    output coord_t col,
    output logic   last
);
    localparam coord_t LAST = coord_t'(LIMIT - 1);

    assign last = (row == LAST) && (col == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + coord_t'(1);
            end else begin
                col <= col + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Sequences one feature-map pass: all conv window origins, a drain wait on the
// MAC pipeline, then all pooling output indices, then holds done until en falls.
module cnn_layer_scheduler
    import cnn_layer_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    cnn_layer_scheduler_if.master dp,
    output logic                  done
);
    sched_state_t state, nxt;
    logic   conv_clr, conv_step, conv_last;
    logic   pool_clr, pool_step, pool_last;
    logic   conv_valid_q, pool_valid_q, done_q;
    coord_t conv_row, conv_col, pool_row, pool_col;

    cnn_win_counter #(.LIMIT(CONV_OFMAP_SIZE)) u_conv_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (conv_clr),
        .step (conv_step),
        .row  (conv_row),
        .col  (conv_col),
        .last (conv_last)
    );

    cnn_win_counter #(.LIMIT(POOL_OFMAP_SIZE)) u_pool_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (pool_clr),
        .step (pool_step),
        .row  (pool_row),
        .col  (pool_col),
        .last (pool_last)
    );

    // Flags are registered from the next state so no ready input reaches an output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            conv_valid_q <= 1'b0;
            pool_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= nxt;
            conv_valid_q <= (nxt == S_CONV);
            pool_valid_q <= (nxt == S_POOL);
            done_q       <= (nxt == S_DONE);
        end
    end

    always_comb begin
        nxt       = state;
        conv_clr  = 1'b0;
        conv_step = 1'b0;
        pool_clr  = 1'b0;
        pool_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    nxt      = S_CONV;
                    conv_clr = 1'b1;
                end
            end
            S_CONV: begin
                if (!en) begin
                    nxt = S_IDLE;
                end else if (conv_valid_q && dp.conv_ready) begin
                    conv_step = 1'b1;
                    if (conv_last) nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!en) begin
                    nxt = S_IDLE;
                end else if (dp.dp_idle) begin
                    nxt      = S_POOL;
                    pool_clr = 1'b1;
                end
            end
            S_POOL: begin
                if (!en) begin
                    nxt = S_IDLE;
                end else if (pool_valid_q && dp.pool_ready) begin
                    pool_step = 1'b1;
                    if (pool_last) nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!en) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign dp.conv_valid = conv_valid_q;
    assign dp.conv_row   = conv_row;
    assign dp.conv_col   = conv_col;
    assign dp.pool_valid = pool_valid_q;
    assign dp.pool_row   = pool_row;
    assign dp.pool_col   = pool_col;
    assign done          = done_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Self-checking bench for cnn_layer_scheduler: queue-based model of one pass,
// fixed and randomized ready/dp_idle patterns, abort and async reset scenarios.
module tb_cnn_layer_scheduler;
    import cnn_layer_scheduler_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;
    logic done;
    int   checks   = 0;
    int   failures = 0;

    cnn_layer_scheduler_if bus ();

    cnn_layer_scheduler dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .dp   (bus),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        en = 1'b0;
        step();
        step();
    endtask

    // One pass from IDLE. mode 0: readies high; 1: conv_ready high on odd cycles;
    // 2: random readies. dp_idle stays low for dp_wait drain cycles. abort_at>=0
    // drops en while that conv beat index is on the bus and returns.
    task automatic run_pass(input string tag, input int mode, input int dp_wait,
                            input int abort_at, output int done_cyc,
                            output int nconv, output int npool);
        int cq_r[$], cq_c[$], pq_r[$], pq_c[$];
        int phase, drain_n, idx;
        bit cr, pr, di;
        for (int r = 0; r < CONV_OFMAP_SIZE; r++)
            for (int c = 0; c < CONV_OFMAP_SIZE; c++) begin cq_r.push_back(r); cq_c.push_back(c); end
        for (int r = 0; r < POOL_OFMAP_SIZE; r++)
            for (int c = 0; c < POOL_OFMAP_SIZE; c++) begin pq_r.push_back(r); pq_c.push_back(c); end
        phase = 0; drain_n = 0; idx = 0; done_cyc = -1; nconv = 0; npool = 0;
        en = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            checks++;
            if (bus.conv_valid !== (phase == 0) || bus.pool_valid !== (phase == 2) || done !== (phase == 3)) begin
                failures++;
                $display("FAIL %s flags cyc=%0d: got cv=%b pv=%b done=%b, expected phase %0d (0=conv 1=drain 2=pool 3=done)",
                         tag, cyc, bus.conv_valid, bus.pool_valid, done, phase);
            end
            if (phase == 0) begin
                checks++;
                if (bus.conv_row !== coord_t'(cq_r[0]) || bus.conv_col !== coord_t'(cq_c[0])) begin
                    failures++;
                    $display("FAIL %s conv_coord cyc=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             tag, cyc, bus.conv_row, bus.conv_col, cq_r[0], cq_c[0]);
                end
            end
            if (phase == 2) begin
                checks++;
                if (bus.pool_row !== coord_t'(pq_r[0]) || bus.pool_col !== coord_t'(pq_c[0])) begin
                    failures++;
                    $display("FAIL %s pool_coord cyc=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             tag, cyc, bus.pool_row, bus.pool_col, pq_r[0], pq_c[0]);
                end
            end
            if (phase == 3) begin
                done_cyc = cyc;
                return;
            end
            if (abort_at >= 0 && phase == 0 && idx == abort_at) begin
                en = 1'b0;
                return;
            end
            case (mode)
                0:       begin cr = 1'b1; pr = 1'b1; end
                1:       begin cr = (cyc % 2 == 1); pr = 1'b1; end
                default: begin cr = 1'($urandom_range(0, 1)); pr = 1'($urandom_range(0, 1)); end
            endcase
            di = (drain_n >= dp_wait);
            bus.conv_ready = cr;
            bus.pool_ready = pr;
            bus.dp_idle    = di;
            if (bus.conv_valid && cr) nconv++;
            if (bus.pool_valid && pr) npool++;
            if (phase == 0 && cr) begin
                void'(cq_r.pop_front()); void'(cq_c.pop_front()); idx++;
                if (cq_r.size() == 0) phase = 1;
            end else if (phase == 1) begin
                if (di) phase = 2; else drain_n++;
            end else if (phase == 2 && pr) begin
                void'(pq_r.pop_front()); void'(pq_c.pop_front());
                if (pq_r.size() == 0) phase = 3;
            end
        end
        checks++; failures++;
        $display("FAIL %s timeout: done not reached within 600 cycles, phase %0d", tag, phase);
    endtask

    task automatic test_reset();
        bus.conv_ready = 1'b0; bus.pool_ready = 1'b0; bus.dp_idle = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0 || done !== 1'b0 ||
            bus.conv_row !== '0 || bus.conv_col !== '0 || bus.pool_row !== '0 || bus.pool_col !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got cv=%b pv=%b done=%b conv=(%0d,%0d) pool=(%0d,%0d) expected all 0",
                     bus.conv_valid, bus.pool_valid, done, bus.conv_row, bus.conv_col, bus.pool_row, bus.pool_col);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL idle_en_low: got cv=%b pv=%b done=%b expected 0 0 0", bus.conv_valid, bus.pool_valid, done);
            end
        end
    endtask

    task automatic test_nominal();
        int dc, nc, np;
        run_pass("nominal", 0, 0, -1, dc, nc, np);
        checks++;
        if (dc !== 46 || nc !== 36 || np !== 9) begin
            failures++;
            $display("FAIL nominal_latency: got done_cyc=%0d conv=%0d pool=%0d expected 46 36 9", dc, nc, np);
        end
        quiesce();
    endtask

    task automatic test_backpressure();
        int dc, nc, np;
        run_pass("backpressure", 1, 0, -1, dc, nc, np);
        checks++;
        if (dc !== 82 || nc !== 36 || np !== 9) begin
            failures++;
            $display("FAIL backpressure_beats: got done_cyc=%0d conv=%0d pool=%0d expected 82 36 9", dc, nc, np);
        end
        quiesce();
    endtask

    task automatic test_drain();
        int dc, nc, np;
        run_pass("drain", 0, 10, -1, dc, nc, np);
        checks++;
        if (dc !== 56) begin
            failures++;
            $display("FAIL drain_wait: got done_cyc=%0d expected 56", dc);
        end
        quiesce();
    endtask

    task automatic test_abort();
        int dc, nc, np;
        run_pass("abort", 0, 0, 2 * CONV_OFMAP_SIZE + 3, dc, nc, np);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL abort_drop cyc=%0d: got cv=%b pv=%b done=%b expected 0 0 0",
                         i, bus.conv_valid, bus.pool_valid, done);
            end
        end
        run_pass("restart", 0, 0, -1, dc, nc, np);
        checks++;
        if (dc !== 46) begin
            failures++;
            $display("FAIL restart_latency: got done_cyc=%0d expected 46", dc);
        end
        quiesce();
    endtask

    task automatic test_done_hold();
        int dc, nc, np;
        run_pass("done_hold", 0, 0, -1, dc, nc, np);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (done !== 1'b1 || bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0) begin
                failures++;
                $display("FAIL done_held cyc=%0d: got done=%b cv=%b pv=%b expected 1 0 0",
                         i, done, bus.conv_valid, bus.pool_valid);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0) begin
                failures++;
                $display("FAIL done_release cyc=%0d: got done=%b cv=%b pv=%b expected 0 0 0",
                         i, done, bus.conv_valid, bus.pool_valid);
            end
        end
    endtask

    task automatic test_random();
        int dc, nc, np;
        for (int k = 0; k < 4; k++) begin
            run_pass("random", 2, int'($urandom_range(0, 5)), -1, dc, nc, np);
            checks++;
            if (nc !== 36 || np !== 9) begin
                failures++;
                $display("FAIL random_beats pass=%0d: got conv=%0d pool=%0d expected 36 9", k, nc, np);
            end
            quiesce();
        end
    endtask

    task automatic test_reset_mid_pool();
        bit seen;
        seen = 1'b0;
        bus.conv_ready = 1'b1; bus.pool_ready = 1'b1; bus.dp_idle = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (bus.pool_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reach_pool: pool_valid=%b after 100 cycles expected 1", bus.pool_valid);
        end
        repeat (4) step();
        checks++;
        if (bus.pool_valid !== 1'b1 || bus.pool_row !== coord_t'(1) || bus.pool_col !== coord_t'(1)) begin
            failures++;
            $display("FAIL pre_reset_pool: got pv=%b (%0d,%0d) expected 1 (1,1)", bus.pool_valid, bus.pool_row, bus.pool_col);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.pool_valid !== 1'b0 || bus.pool_row !== '0 || bus.pool_col !== '0 ||
            bus.conv_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got pv=%b (%0d,%0d) cv=%b done=%b expected all 0",
                     bus.pool_valid, bus.pool_row, bus.pool_col, bus.conv_valid, done);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.conv_valid !== 1'b0 || bus.pool_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: got cv=%b pv=%b done=%b expected 0 0 0", bus.conv_valid, bus.pool_valid, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_drain();
        test_abort();
        test_done_hold();
        test_random();
        test_reset_mid_pool();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
